// File: rtl/fixed_to_float.sv
// fixed_to_float: iterative unsigned-integer to {E,M} minifloat encoder with valid/ready on both sides
module fixed_to_float #(
  parameter int IN_W  = 16,
  parameter int EXP_W = 3,
  parameter int MAN_W = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IN_W-1:0]        in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W-1:0] out_data,
  output logic                   inexact,
  output logic                   overflow
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t stateQ, stateD;
  logic [IN_W-1:0] acc;
  logic [EXP_W-1:0] exp;
  logic sticky, fits, sat;
  always_comb begin
    fits = acc[IN_W-1:MAN_W] == '0;
    sat = exp == '1;
    stateD = stateQ == IDLE  ? (in_valid ? SHIFT : IDLE) :
             stateQ == SHIFT ? (fits || sat ? DONE : SHIFT) :
                               (out_ready ? IDLE : DONE);
    in_ready = stateQ == IDLE && !rst;
    out_valid = stateQ == DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ <= IDLE;
      acc <= '0;
      exp <= '0;
      sticky <= 1'b0;
      out_data <= '0;
      inexact <= 1'b0;
      overflow <= 1'b0;
    end else begin
      stateQ <= stateD;
      if (stateQ == IDLE && in_valid) begin
        acc <= in_data;
        exp <= '0;
        sticky <= 1'b0;
      end
      // a small value wins over exp saturation so 3969..4095 truncate instead of overflowing
      if (stateQ == SHIFT) begin
        if (fits) begin
          out_data <= {exp, acc[MAN_W-1:0]};
          inexact <= sticky;
          overflow <= 1'b0;
        end else if (sat) begin
          out_data <= '1;
          inexact <= 1'b0;
          overflow <= 1'b1;
        end else begin
          acc <= acc >> 1;
          exp <= exp + 1'b1;
          sticky <= sticky | acc[0];
        end
      end
    end
  end
endmodule
